// File: rtl/bus_arbiter_pkg.sv
// Shared state encodings and master indices for the two-master bus arbiter.
// The encodings are visible on the debug owner port.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic arb_state_t own_state(input logic m);
    return m ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter_beat_counter.sv
// Saturating count of acked beats in the current grant. It flags when the
// next acked beat would reach MAX_BEATS.
module arb_beat_counter #(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic limit
);

  localparam logic [CNT_W-1:0] SAT      = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

  logic [CNT_W-1:0] count;

  // Holds at MAX_BEATS so an uncontended burst can run indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && count != SAT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign limit = (count >= LAST_IDX);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the CPU MEM stage (master 0) and a secondary
// master (master 1) for the single Bridge data port, with bounded bursts.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_wen,
  output logic [DATA_W-1:0] Bus_wdata,
  input  logic [DATA_W-1:0] Bus_rdata,
  output logic              cpu_stall,
  output logic [1:0]        owner
);

  arb_state_t state, next_state;
  logic       rr_last, next_rr_last;
  logic       own_idx, own_req, other_req;
  logic       limit;

  assign own_idx   = (state == ARB_OWN1);
  assign own_req   = own_idx ? m1_req : m0_req;
  assign other_req = own_idx ? m0_req : m1_req;

  // Ownership passes on a req drop or once a contended burst hits its cap.
  always_comb begin
    next_state   = state;
    next_rr_last = rr_last;
    case (state)
      ARB_IDLE: begin
        if (m0_req && m1_req) next_state = own_state(~rr_last);
        else if (m0_req)      next_state = ARB_OWN0;
        else if (m1_req)      next_state = ARB_OWN1;
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!own_req) begin
          next_rr_last = own_idx;
          next_state   = other_req ? own_state(~own_idx) : ARB_IDLE;
        end else if (limit && other_req) begin
          next_rr_last = own_idx;
          next_state   = own_state(~own_idx);
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state   <= ARB_IDLE;
      rr_last <= ARB_M1;
    end else begin
      state   <= next_state;
      rr_last <= next_rr_last;
    end
  end

  arb_beat_counter #(.MAX_BEATS(MAX_BEATS)) u_beat_counter (
    .clk   (cpu_clk),
    .rst_n (cpu_rst),
    .clear (next_state != state),
    .incr  (m0_ack | m1_ack),
    .limit (limit)
  );

  // Bus_wen is gated by the owner's req, so it can never fire without an ack.
  always_comb begin
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    Bus_addr  = '0;
    Bus_wen   = 1'b0;
    Bus_wdata = '0;
    case (state)
      ARB_OWN0: begin
        m0_ack    = m0_req;
        m0_rdata  = Bus_rdata;
        Bus_addr  = m0_addr;
        Bus_wen   = m0_wen & m0_req;
        Bus_wdata = m0_wdata;
      end
      ARB_OWN1: begin
        m1_ack    = m1_req;
        m1_rdata  = Bus_rdata;
        Bus_addr  = m1_addr;
        Bus_wen   = m1_wen & m1_req;
        Bus_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = m0_req & ~m0_ack;
  assign owner     = state;

endmodule
